morse_beep_scheduler: RTL and testbench

//  Plays queued Morse letters on the buzzer with standard timing: dot 1 unit, dash 3 units,
//  1-unit gap between elements, 3-unit gap after each letter, 7-unit silent word gap.

---
 rtl/morse_beep_scheduler.sv | 207 ++++++++++++++++++++
 tb/tb_morse_beep_scheduler.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_beep_scheduler.sv
// morse_beep_scheduler
//   Plays queued Morse letters on a buzzer pin using standard timing:
//   dot = 1 unit, dash = 3 units, 1-unit gap between elements,
//   3-unit gap after each letter, and a 7-unit silent word space.
//   A small letter FIFO sits in front of the sequencer. abort_i flushes
//   the FIFO and stops playback.
//
// Ports
//   clk_i          system clock
//   rst_i          synchronous active-high reset
//   sym_valid_i    producer offers a letter this cycle
//   sym_ready_o    FIFO can accept (push = valid && ready)
//   sym_len_i[2:0] element count 1..5, 0 = word space, 6/7 clamp to 5
//   sym_bits_i[4:0] bit i = element i (1 dash, 0 dot), bit 0 first
//   speed_i[1:0]   unit = UNIT_CYCLES*(speed+1), sampled at pop
//   mute_i         silences beep_o, timing unaffected
//   abort_i        flush FIFO, return to idle
//   beep_o         square-wave buzzer drive (registered)
//   busy_o         sequencer active or FIFO non-empty
//   letter_done_o  pulse on the last cycle of a letter/word-space gap
//   fifo_count_o   entries queued
//
// state      | meaning
// -----------+-------------------------------------------
// S_IDLE     | waiting; pops the FIFO head when available
// S_TONE     | sounding the current element (1 or 3 units)
// S_GAP_ELEM | 1-unit silence between elements
// S_GAP_LET  | 3-unit silence after the final element
// S_GAP_WORD | 7-unit silence for a word space
module morse_beep_scheduler #(
  parameter int unsigned UNIT_CYCLES = 20_000_000,
  parameter int unsigned TONE_HALF   = 50_000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sym_valid_i,
  output logic       sym_ready_o,
  input  logic [2:0] sym_len_i,
  input  logic [4:0] sym_bits_i,
  input  logic [1:0] speed_i,
  input  logic       mute_i,
  input  logic       abort_i,
  output logic       beep_o,
  output logic       busy_o,
  output logic       letter_done_o,
  output logic [2:0] fifo_count_o
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [2:0] DEPTH_C = 3'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_TONE     = 3'd1;
  localparam logic [2:0] S_GAP_ELEM = 3'd2;
  localparam logic [2:0] S_GAP_LET  = 3'd3;
  localparam logic [2:0] S_GAP_WORD = 3'd4;

  // FIFO entries hold {clamped length, element bits}
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0]    count_q;

  logic [2:0]  state_q, state_d;
  logic [31:0] unit_len_q, unit_len_d;
  logic [31:0] unit_cnt_q, unit_cnt_d;
  logic [2:0]  units_q, units_d;
  logic [2:0]  len_q, len_d;
  logic [4:0]  bits_q, bits_d;
  logic [2:0]  idx_q, idx_d;
  logic        phase_q, phase_d;
  logic [31:0] tone_cnt_q, tone_cnt_d;
  logic        beep_q, beep_d;

  logic       push, pop;
  logic [7:0] head;
  logic [2:0] len_clamped;
  logic [2:0] need_units;
  logic       unit_end, seg_end;

  assign sym_ready_o  = (count_q < DEPTH_C) && !abort_i;
  assign push         = sym_valid_i && sym_ready_o;
  assign pop          = (state_q == S_IDLE) && (count_q != 3'd0) && !abort_i;
  assign head         = fifo_q[rd_ptr_q];
  assign len_clamped  = (sym_len_i > 3'd5) ? 3'd5 : sym_len_i;

  always_comb begin
    need_units = 3'd1;
    case (state_q)
      S_TONE:     need_units = bits_q[idx_q] ? 3'd3 : 3'd1;
      S_GAP_LET:  need_units = 3'd3;
      S_GAP_WORD: need_units = 3'd7;
      default:    need_units = 3'd1;
    endcase
  end

  // a segment is measured in whole units: cycle counter within the unit,
  // plus a count of completed units within the segment
  assign unit_end = (unit_cnt_q == unit_len_q - 32'd1);
  assign seg_end  = unit_end && (units_q == need_units - 3'd1);

  always_comb begin
    state_d    = state_q;
    unit_len_d = unit_len_q;
    unit_cnt_d = unit_cnt_q;
    units_d    = units_q;
    len_d      = len_q;
    bits_d     = bits_q;
    idx_d      = idx_q;
    phase_d    = phase_q;
    tone_cnt_d = tone_cnt_q;

    if (state_q == S_IDLE) begin
      if (pop) begin
        unit_len_d = 32'(UNIT_CYCLES) * (32'(speed_i) + 32'd1);
        len_d      = head[7:5];
        bits_d     = head[4:0];
        idx_d      = 3'd0;
        unit_cnt_d = 32'd0;
        units_d    = 3'd0;
        state_d    = (head[7:5] == 3'd0) ? S_GAP_WORD : S_TONE;
      end
    end else if (seg_end) begin
      unit_cnt_d = 32'd0;
      units_d    = 3'd0;
      case (state_q)
        S_TONE:     state_d = (idx_q + 3'd1 < len_q) ? S_GAP_ELEM : S_GAP_LET;
        S_GAP_ELEM: begin
          idx_d   = idx_q + 3'd1;
          state_d = S_TONE;
        end
        default:    state_d = S_IDLE;
      endcase
    end else if (unit_end) begin
      unit_cnt_d = 32'd0;
      units_d    = units_q + 3'd1;
    end else begin
      unit_cnt_d = unit_cnt_q + 32'd1;
    end

    if (abort_i) state_d = S_IDLE;

    // each tone starts on the high half of the square wave
    if (state_d == S_TONE && state_q != S_TONE) begin
      phase_d    = 1'b1;
      tone_cnt_d = 32'd0;
    end else if (state_q == S_TONE) begin
      if (tone_cnt_q == 32'(TONE_HALF) - 32'd1) begin
        tone_cnt_d = 32'd0;
        phase_d    = !phase_q;
      end else begin
        tone_cnt_d = tone_cnt_q + 32'd1;
      end
    end

    // registered from next-state so the pin lines up with the TONE cycles
    beep_d = (state_d == S_TONE) && phase_d && !mute_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || abort_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 3'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= {len_clamped, sym_bits_i};
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop)      count_q <= count_q + 3'd1;
      else if (pop && !push) count_q <= count_q - 3'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      unit_len_q <= 32'(UNIT_CYCLES);
      unit_cnt_q <= 32'd0;
      units_q    <= 3'd0;
      len_q      <= 3'd0;
      bits_q     <= 5'd0;
      idx_q      <= 3'd0;
      phase_q    <= 1'b0;
      tone_cnt_q <= 32'd0;
      beep_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      unit_len_q <= unit_len_d;
      unit_cnt_q <= unit_cnt_d;
      units_q    <= units_d;
      len_q      <= len_d;
      bits_q     <= bits_d;
      idx_q      <= idx_d;
      phase_q    <= phase_d;
      tone_cnt_q <= tone_cnt_d;
      beep_q     <= beep_d;
    end
  end

  assign beep_o        = beep_q;
  assign busy_o        = (state_q != S_IDLE) || (count_q != 3'd0);
  assign letter_done_o = ((state_q == S_GAP_LET) || (state_q == S_GAP_WORD)) && seg_end && !abort_i;
  assign fifo_count_o  = count_q;

endmodule

// File: tb/tb_morse_beep_scheduler.sv
module tb_morse_beep_scheduler;

  localparam int UNIT = 10;
  localparam int TH   = 2;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       sym_valid_i = 1'b0;
  logic       sym_ready_o;
  logic [2:0] sym_len_i = 3'd0;
  logic [4:0] sym_bits_i = 5'd0;
  logic [1:0] speed_i = 2'd0;
  logic       mute_i = 1'b0;
  logic       abort_i = 1'b0;
  logic       beep_o, busy_o, letter_done_o;
  logic [2:0] fifo_count_o;

  morse_beep_scheduler #(.UNIT_CYCLES(UNIT), .TONE_HALF(TH), .FIFO_DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .sym_valid_i(sym_valid_i), .sym_ready_o(sym_ready_o),
    .sym_len_i(sym_len_i), .sym_bits_i(sym_bits_i), .speed_i(speed_i), .mute_i(mute_i),
    .abort_i(abort_i), .beep_o(beep_o), .busy_o(busy_o), .letter_done_o(letter_done_o),
    .fifo_count_o(fifo_count_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // FIFO of {len,bits}; timeline holds one entry per future cycle of the
  // letter being played: bit0 = tone-high, bit1 = last cycle of the letter.
  logic [7:0] fq[$];
  logic [1:0] tl[$];
  logic       mute_prev = 1'b0;
  bit         chk_en = 1'b0;

  function automatic void expand(input logic [7:0] e, input int unit);
    int len;
    len = int'(e[7:5]);
    if (len == 0) begin
      for (int k = 0; k < 7 * unit; k++) tl.push_back(2'b00);
    end else begin
      for (int el = 0; el < len; el++) begin
        int d;
        d = e[el] ? 3 : 1;
        for (int k = 0; k < d * unit; k++) tl.push_back({1'b0, ((k / TH) % 2) == 0});
        if (el < len - 1) for (int k = 0; k < unit; k++) tl.push_back(2'b00);
      end
      for (int k = 0; k < 3 * unit; k++) tl.push_back(2'b00);
    end
    tl[tl.size()-1] = tl[tl.size()-1] | 2'b10;
  endfunction

  always @(posedge clk) begin
    bit do_push;
    logic [2:0] cl;
    do_push = sym_valid_i && (fq.size() < 4) && !abort_i;
    cl = (sym_len_i > 3'd5) ? 3'd5 : sym_len_i;
    if (rst_i || abort_i) begin
      fq.delete();
      tl.delete();
    end else begin
      if (tl.size() > 0) void'(tl.pop_front());
      else if (fq.size() > 0) expand(fq.pop_front(), UNIT * (int'(speed_i) + 1));
      if (do_push) fq.push_back({cl, sym_bits_i});
    end
    mute_prev <= mute_i;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit has;
      has = tl.size() > 0;
      chk("m_ready", int'(sym_ready_o), int'((fq.size() < 4) && !abort_i));
      chk("m_count", int'(fifo_count_o), fq.size());
      chk("m_busy",  int'(busy_o), int'(has || fq.size() > 0));
      chk("m_beep",  int'(beep_o), int'(has && tl[0][0] && !mute_prev));
      chk("m_done",  int'(letter_done_o), int'(has && tl[0][1] && !abort_i));
    end
  end

  // ---------------- directed table ----------------
  typedef struct {
    logic [2:0] len;
    logic [4:0] bits;
    logic [1:0] spd;
    logic       mute;
    int         done_at;
    int         highs;
  } vec_t;
  vec_t tbl[9];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk);
      if (!busy_o) ok = 1'b1;
      tick();
    end
    chk(nm, int'(ok), 1);
  endtask

  task automatic run_entry(input int i);
    int cyc, highs, done_at, first;
    sym_valid_i = 1'b1; sym_len_i = tbl[i].len; sym_bits_i = tbl[i].bits;
    speed_i = tbl[i].spd; mute_i = tbl[i].mute;
    tick();
    sym_valid_i = 1'b0;
    cyc = 1; highs = 0; done_at = -1; first = -1;
    for (int k = 0; k < 1000 && done_at < 0; k++) begin
      @(negedge clk);
      if (beep_o) begin
        highs++;
        if (first < 0) first = cyc;
      end
      if (letter_done_o) done_at = cyc;
      tick();
      cyc++;
    end
    chk($sformatf("t%0d_done_cycle", i), done_at, tbl[i].done_at);
    chk($sformatf("t%0d_beep_highs", i), highs, tbl[i].highs);
    if (tbl[i].highs > 0) chk($sformatf("t%0d_first_beep", i), first, 2);
    @(negedge clk);
    chk($sformatf("t%0d_busy_after", i), int'(busy_o), 0);
    tick();
    mute_i = 1'b0; speed_i = 2'd0;
  endtask

  initial begin
    int cyc, acc, acc_cycle, done1, done2;

    tbl[0] = '{3'd1, 5'b00000, 2'd0, 1'b0,  41,  6};
    tbl[1] = '{3'd2, 5'b00010, 2'd0, 1'b0,  81, 22};
    tbl[2] = '{3'd2, 5'b00010, 2'd0, 1'b1,  81,  0};
    tbl[3] = '{3'd2, 5'b00010, 2'd1, 1'b0, 161, 40};
    tbl[4] = '{3'd1, 5'b00001, 2'd0, 1'b0,  61, 16};
    tbl[5] = '{3'd0, 5'b00000, 2'd0, 1'b0,  71,  0};
    tbl[6] = '{3'd7, 5'b11111, 2'd0, 1'b0, 221, 80};
    tbl[7] = '{3'd6, 5'b10101, 2'd0, 1'b0, 181, 60};
    tbl[8] = '{3'd1, 5'b00000, 2'd3, 1'b0, 161, 20};

    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_beep", int'(beep_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(letter_done_o), 0);
    chk("rst_count", int'(fifo_count_o), 0);
    chk("rst_ready", int'(sym_ready_o), 1);
    tick();

    for (int i = 0; i < 9; i++) run_entry(i);

    // FIFO full while a dash letter plays; 5th letter waits for the pop
    sym_valid_i = 1'b1; sym_len_i = 3'd1; sym_bits_i = 5'b00001;
    tick();
    sym_valid_i = 1'b0; tick();
    sym_len_i = 3'd1; sym_bits_i = 5'b00000;
    cyc = 2; acc = 0; acc_cycle = -1;
    sym_valid_i = 1'b1;
    for (int k = 0; k < 200 && acc < 5; k++) begin
      @(negedge clk);
      if (sym_ready_o) begin
        acc++;
        if (acc == 5) acc_cycle = cyc;
      end
      if (cyc == 10) begin
        chk("full_ready_low", int'(sym_ready_o), 0);
        chk("full_count", int'(fifo_count_o), 4);
      end
      tick();
      cyc++;
    end
    sym_valid_i = 1'b0;
    chk("fifth_accept_cycle", acc_cycle, 63);
    wait_idle("drain_full", 600);

    // abort mid-dash with two letters queued, push offered in the abort cycle
    sym_valid_i = 1'b1; sym_len_i = 3'd1; sym_bits_i = 5'b00001; tick();
    sym_bits_i = 5'b00000; tick();
    tick();
    sym_valid_i = 1'b0;
    repeat (12) tick();
    abort_i = 1'b1; sym_valid_i = 1'b1;
    @(negedge clk);
    chk("abort_ready", int'(sym_ready_o), 0);
    chk("abort_count_before", int'(fifo_count_o), 2);
    tick();
    abort_i = 1'b0; sym_valid_i = 1'b0;
    @(negedge clk);
    chk("abort_beep", int'(beep_o), 0);
    chk("abort_count", int'(fifo_count_o), 0);
    chk("abort_busy", int'(busy_o), 0);
    tick();
    begin
      int dn;
      dn = 0;
      for (int k = 0; k < 80; k++) begin
        @(negedge clk);
        if (letter_done_o) dn++;
        tick();
      end
      chk("abort_no_done", dn, 0);
    end

    // reset in the middle of a letter
    sym_valid_i = 1'b1; sym_len_i = 3'd2; sym_bits_i = 5'b00010; tick();
    sym_valid_i = 1'b1; sym_len_i = 3'd1; tick();
    sym_valid_i = 1'b0;
    repeat (20) tick();
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    @(negedge clk);
    chk("midrst_beep", int'(beep_o), 0);
    chk("midrst_busy", int'(busy_o), 0);
    chk("midrst_count", int'(fifo_count_o), 0);
    chk("midrst_ready", int'(sym_ready_o), 1);
    tick();

    // word space followed by a clamped len=7 all-dash letter
    sym_valid_i = 1'b1; sym_len_i = 3'd0; sym_bits_i = 5'b00000; tick();
    sym_len_i = 3'd7; sym_bits_i = 5'b11111; tick();
    sym_valid_i = 1'b0;
    cyc = 2; done1 = -1; done2 = -1;
    for (int k = 0; k < 400 && done2 < 0; k++) begin
      @(negedge clk);
      if (letter_done_o) begin
        if (done1 < 0) done1 = cyc; else done2 = cyc;
      end
      tick();
      cyc++;
    end
    chk("word_done", done1, 71);
    chk("clamp_done", done2, 292);

    // randomized traffic against the reference model
    for (int c = 0; c < 12000; c++) begin
      rst_i       = ($urandom_range(0, 999) == 0);
      abort_i     = ($urandom_range(0, 499) == 0);
      sym_valid_i = ($urandom_range(0, 99) < 15);
      sym_len_i   = 3'($urandom_range(0, 7));
      sym_bits_i  = 5'($urandom);
      if ($urandom_range(0, 199) == 0) speed_i = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) mute_i = !mute_i;
      tick();
    end
    rst_i = 1'b0; abort_i = 1'b0; sym_valid_i = 1'b0; mute_i = 1'b0;
    wait_idle("final_drain", 6000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
